ex_mem_pipe: RTL and testbench
==============================

EX_MEM_PIPE -- requirements
Module: ex_mem_pipe

Interface
REQ-001 SHALL take parameter XLEN, default 32, datapath width of result, store-data, target and PC fields.
REQ-002 SHALL have port i_clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port i_valid, input, 1, execute stage presents a payload.
REQ-005 SHALL have port o_ready, output, 1, this block accepts the payload this cycle.
REQ-006 SHALL have port i_flush, input, 1, kill all held and incoming entries.
REQ-007 SHALL have ports i_result, i_reg2, i_target, i_pc, inputs, XLEN each: ALU result/address, store data, branch target, next PC.
REQ-008 SHALL have ports i_eq, i_slt, i_unsigned, inputs, 1 each: compare flags, unsigned-load flag.
REQ-009 SHALL have ports i_mask (4), i_rd_waddr (5), i_uimm (XLEN), i_ctrl (8): inputs for byte mask, destination register, U-immediate, packed control.
REQ-010 SHALL have output ports o_result, o_reg2, o_target, o_pc, o_eq, o_slt, o_unsigned, o_mask, o_rd_waddr, o_uimm, o_ctrl, same widths as their i_ counterparts.
REQ-011 SHALL have port o_valid, output, 1, memory stage payload valid.
REQ-012 SHALL have port i_ready, input, 1, memory stage consumes the payload this cycle.
REQ-013 SHALL have port o_misalign, output, 1, the held access violates alignment.

Function
REQ-014 SHALL transfer upstream on i_valid & o_ready and downstream on o_valid & i_ready.
REQ-015 SHALL hold all o_ payload stable while o_valid & !i_ready.
REQ-016 SHALL present a newly accepted payload on outputs the cycle after acceptance (latency 1) when the output slot is empty or draining.
REQ-017 SHALL drive o_ctrl to 8'h00 whenever o_valid is 0, so no bubble writes memory or the register file.
REQ-018 SHALL, on i_flush, clear o_valid and skid-entry valid at the next edge and ignore the same-cycle upstream payload; flush overrides simultaneous accept and consume.
REQ-019 SHALL assert o_misalign when o_valid & (MemRead|MemWrite) and: mask 1111 with o_result[1:0]!=0, or mask 0011/1100 with o_result[0]!=0.
REQ-020 SHALL treat a mask other than 1111, 1100, 0110, 0011, 1000, 0100, 0010, 0001 on a memory access as misaligned.
REQ-021 SHALL accept and emit in the same cycle when full and i_ready=1, with no throughput bubble.

Reset
REQ-022 SHALL, while i_rst_n=0, force o_valid=0, skid valid=0, o_ctrl=0, all other o_ payload=0, o_misalign=0.
REQ-023 SHALL drive o_ready=1 from the first edge after reset release; a reset mid-stall discards held entries.

Configuration
REQ-024 SHALL, with EX_MEM_SKID_EN defined, include a one-entry skid buffer: o_ready is a register equal to !skid_valid; a payload arriving while stalled is parked and promoted when the output drains; oldest-first order is preserved.
REQ-025 SHALL, without EX_MEM_SKID_EN, contain no skid storage: o_ready = !o_valid | i_ready (combinational).

Structure
REQ-026 SHALL import from the shared package cpu_pkg the i_ctrl bit indices (Jump=0, BranchEqual=1, BranchLT=2, MemRead=3, MemWrite=4, MemtoReg=5, RegWrite=6, IsUInstruct=7) and the legal mask constants.
REQ-027 SHALL place payload storage in one sub-module, pipe_slot, instanced once for the output slot and once more for the skid entry when EX_MEM_SKID_EN is defined.

Verification
REQ-028 SHALL cover: reset release, i_valid=1, i_result=32'h10, i_ctrl=8'h48, i_ready=1 -> next cycle o_valid=1, o_result=32'h10, o_ctrl=8'h48.
REQ-029 SHALL cover: output full with i_ready=0 for 3 cycles, new i_valid (skid on) -> o_ready drops after 1 parked entry, outputs unchanged, both entries emitted in order once i_ready=1.
REQ-030 SHALL cover: i_flush=1 with full slot, skid entry and i_valid=1 -> next cycle o_valid=0, o_ctrl=0, o_ready=1.
REQ-031 SHALL cover: MemRead, i_mask=4'b1111, i_result=32'h1002 -> o_misalign=1; i_mask=4'b0011, i_result=32'h1002 -> o_misalign=0.
REQ-032 SHALL cover: i_rst_n dropped asynchronously mid-stall -> o_valid=0 immediately, no payload reappears after release.
REQ-033 SHALL cover: continuous i_valid=1, i_ready=1 for 8 cycles -> 8 payloads emitted back-to-back with no bubble.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared control-bit indices and legal byte-mask encodings for the CPU pipeline.
package cpu_pkg;
  localparam int CTRL_JUMP = 0;
  localparam int CTRL_BRANCH_EQ = 1;
  localparam int CTRL_BRANCH_LT = 2;
  localparam int CTRL_MEM_READ = 3;
  localparam int CTRL_MEM_WRITE = 4;
  localparam int CTRL_MEM_TO_REG = 5;
  localparam int CTRL_REG_WRITE = 6;
  localparam int CTRL_IS_UINST = 7;
  localparam logic [3:0] MASK_WORD = 4'b1111;
  localparam logic [3:0] MASK_HALF_HI = 4'b1100;
  localparam logic [3:0] MASK_HALF_MID = 4'b0110;
  localparam logic [3:0] MASK_HALF_LO = 4'b0011;
  localparam logic [3:0] MASK_BYTE3 = 4'b1000;
  localparam logic [3:0] MASK_BYTE2 = 4'b0100;
  localparam logic [3:0] MASK_BYTE1 = 4'b0010;
  localparam logic [3:0] MASK_BYTE0 = 4'b0001;
  function automatic logic mask_legal(input logic [3:0] m);
    return m inside {MASK_WORD, MASK_HALF_HI, MASK_HALF_MID, MASK_HALF_LO,
                     MASK_BYTE3, MASK_BYTE2, MASK_BYTE1, MASK_BYTE0};
  endfunction
endpackage

// File: rtl/ex_mem_pipe_slot.sv
// pipe_slot: one payload register with valid bit; data only loads when a valid entry is written.
module pipe_slot #(
  parameter int W = 148
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         v_in,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid <= 1'b0;
      q <= '0;
    end else if (en) begin
      valid <= v_in;
      if (v_in) q <= d;
    end
endmodule

// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: EX->MEM valid/ready pipeline register with alignment check.
// Define EX_MEM_SKID_EN to add a one-entry skid buffer with a registered o_ready.
module ex_mem_pipe
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_result,
  input  logic [XLEN-1:0] i_reg2,
  input  logic [XLEN-1:0] i_target,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_eq,
  input  logic            i_slt,
  input  logic            i_unsigned,
  input  logic [3:0]      i_mask,
  input  logic [4:0]      i_rd_waddr,
  input  logic [XLEN-1:0] i_uimm,
  input  logic [7:0]      i_ctrl,
  output logic [XLEN-1:0] o_result,
  output logic [XLEN-1:0] o_reg2,
  output logic [XLEN-1:0] o_target,
  output logic [XLEN-1:0] o_pc,
  output logic            o_eq,
  output logic            o_slt,
  output logic            o_unsigned,
  output logic [3:0]      o_mask,
  output logic [4:0]      o_rd_waddr,
  output logic [XLEN-1:0] o_uimm,
  output logic [7:0]      o_ctrl,
  output logic            o_valid,
  input  logic            i_ready,
  output logic            o_misalign
);
  localparam int W = 5 * XLEN + 20;
  logic [W-1:0] d_in, out_q;
  logic [7:0] ctrl_q;
  logic acc, mem, bad;
  assign d_in = {i_result, i_reg2, i_target, i_pc, i_eq, i_slt, i_unsigned,
                 i_mask, i_rd_waddr, i_uimm, i_ctrl};
  assign {o_result, o_reg2, o_target, o_pc, o_eq, o_slt, o_unsigned,
          o_mask, o_rd_waddr, o_uimm, ctrl_q} = out_q;
  assign acc = i_valid & o_ready;
`ifdef EX_MEM_SKID_EN
  logic skid_valid, drain;
  logic [W-1:0] skid_q;
  assign o_ready = !skid_valid;
  assign drain = !o_valid | i_ready;
  pipe_slot #(.W(W)) u_out (
    .clk(i_clk), .rst_n(i_rst_n), .en(i_flush | drain),
    .v_in(!i_flush & (skid_valid | acc)), .d(skid_valid ? skid_q : d_in),
    .valid(o_valid), .q(out_q)
  );
  // parks only while stalled; promoted to the output slot as soon as it drains
  pipe_slot #(.W(W)) u_skid (
    .clk(i_clk), .rst_n(i_rst_n), .en(i_flush | (skid_valid ? drain : acc & !drain)),
    .v_in(!i_flush & !skid_valid), .d(d_in),
    .valid(skid_valid), .q(skid_q)
  );
`else
  assign o_ready = !o_valid | i_ready;
  pipe_slot #(.W(W)) u_out (
    .clk(i_clk), .rst_n(i_rst_n), .en(i_flush | o_ready),
    .v_in(!i_flush & acc), .d(d_in),
    .valid(o_valid), .q(out_q)
  );
`endif
  assign o_ctrl = o_valid ? ctrl_q : 8'h00;
  assign mem = ctrl_q[CTRL_MEM_READ] | ctrl_q[CTRL_MEM_WRITE];
  assign bad = !mask_legal(o_mask)
             | (o_mask == MASK_WORD && o_result[1:0] != 2'b00)
             | ((o_mask == MASK_HALF_LO || o_mask == MASK_HALF_HI) && o_result[0]);
  assign o_misalign = o_valid & mem & bad;
endmodule

// File: tb/tb_ex_mem_pipe.sv
// tb_ex_mem_pipe: directed checks of handshake, stall, flush, reset and alignment for ex_mem_pipe.
module tb_ex_mem_pipe;
  logic        clk = 0, rst_n = 0, i_valid = 0, i_flush = 0, i_ready = 0;
  logic        o_ready, o_valid, o_misalign;
  logic [31:0] i_result = 0, i_reg2 = 0, i_target = 0, i_pc = 0, i_uimm = 0;
  logic [31:0] o_result, o_reg2, o_target, o_pc, o_uimm;
  logic        i_eq = 0, i_slt = 0, i_unsigned = 0, o_eq, o_slt, o_unsigned;
  logic [3:0]  i_mask = 0, o_mask;
  logic [4:0]  i_rd_waddr = 0, o_rd_waddr;
  logic [7:0]  i_ctrl = 0, o_ctrl;
  int checks = 0, errors = 0;

  ex_mem_pipe #(.XLEN(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_flush(i_flush),
    .i_result(i_result), .i_reg2(i_reg2), .i_target(i_target), .i_pc(i_pc),
    .i_eq(i_eq), .i_slt(i_slt), .i_unsigned(i_unsigned), .i_mask(i_mask),
    .i_rd_waddr(i_rd_waddr), .i_uimm(i_uimm), .i_ctrl(i_ctrl),
    .o_result(o_result), .o_reg2(o_reg2), .o_target(o_target), .o_pc(o_pc),
    .o_eq(o_eq), .o_slt(o_slt), .o_unsigned(o_unsigned), .o_mask(o_mask),
    .o_rd_waddr(o_rd_waddr), .o_uimm(o_uimm), .o_ctrl(o_ctrl),
    .o_valid(o_valid), .i_ready(i_ready), .o_misalign(o_misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic [7:0] c, input logic [3:0] m);
    i_valid = v;
    i_result = r;
    i_ctrl = c;
    i_mask = m;
    i_reg2 = r ^ 32'hffff;
    i_rd_waddr = r[4:0];
  endtask

  initial begin
    #1;
    check("rst_valid", o_valid, 0);
    check("rst_ctrl", o_ctrl, 0);
    check("rst_result", o_result, 0);
    check("rst_misalign", o_misalign, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    step();
    check("ready_after_rst", o_ready, 1);

    // single payload flows with latency 1, then bubble has ctrl 0
    i_ready = 1;
    drive(1, 32'h10, 8'h48, 4'b1111);
    step();
    drive(0, 0, 0, 0);
    check("lat1_valid", o_valid, 1);
    check("lat1_result", o_result, 32'h10);
    check("lat1_ctrl", o_ctrl, 8'h48);
    check("lat1_reg2", o_reg2, 32'h10 ^ 32'hffff);
    check("lat1_misalign", o_misalign, 0);
    step();
    check("bubble_valid", o_valid, 0);
    check("bubble_ctrl", o_ctrl, 0);

    // stall: A held in output, B arrives behind it
    i_ready = 0;
    drive(1, 32'hA0, 8'h40, 4'b1111);
    step();
    check("stall_a_valid", o_valid, 1);
    drive(1, 32'hB0, 8'h44, 4'b1111);
    #1;
`ifdef EX_MEM_SKID_EN
    check("skid_ready_pre", o_ready, 1);
    step();
    drive(1, 32'hC0, 8'h40, 4'b1111);
`else
    check("noskid_ready_stall", o_ready, 0);
    step();
`endif
    for (int i = 0; i < 3; i++) begin
      check("stall_ready", o_ready, 0);
      check("stall_result", o_result, 32'hA0);
      check("stall_ctrl", o_ctrl, 8'h40);
      step();
    end
`ifdef EX_MEM_SKID_EN
    drive(0, 0, 0, 0);
    i_ready = 1;
`else
    i_ready = 1;
    #1;
    check("noskid_ready_drain", o_ready, 1);
    step();
    drive(0, 0, 0, 0);
    check("order_b_result", o_result, 32'hB0);
    check("order_b_ctrl", o_ctrl, 8'h44);
`endif
`ifdef EX_MEM_SKID_EN
    step();
    check("order_b_result", o_result, 32'hB0);
    check("order_b_ctrl", o_ctrl, 8'h44);
    check("skid_ready_back", o_ready, 1);
`endif
    step();
    check("order_empty", o_valid, 0);

    // flush with full output (and parked entry under skid) plus incoming payload
    i_ready = 0;
    drive(1, 32'hD0, 8'h50, 4'b1111);
    step();
    drive(1, 32'hE0, 8'h50, 4'b1111);
    step();
    drive(1, 32'hF0, 8'h50, 4'b1111);
    i_flush = 1;
    step();
    i_flush = 0;
    drive(0, 0, 0, 0);
    check("flush_valid", o_valid, 0);
    check("flush_ctrl", o_ctrl, 0);
    check("flush_ready", o_ready, 1);
    i_ready = 1;
    step();
    check("flush_no_reappear", o_valid, 0);

    // alignment cases: {ctrl, mask, result, expected}
    begin
      logic [7:0]  c [6] = '{8'h08, 8'h08, 8'h08, 8'h40, 8'h10, 8'h10};
      logic [3:0]  m [6] = '{4'b1111, 4'b0011, 4'b0101, 4'b0000, 4'b1100, 4'b0001};
      logic [31:0] r [6] = '{32'h1002, 32'h1002, 32'h1000, 32'h1003, 32'h1001, 32'h1003};
      logic        e [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 6; i++) begin
        drive(1, r[i], c[i], m[i]);
        step();
        check($sformatf("misalign_%0d", i), o_misalign, e[i]);
      end
      drive(0, 0, 0, 0);
      step();
      check("misalign_bubble", o_misalign, 0);
    end

    // async reset mid-stall
    i_ready = 0;
    drive(1, 32'h77, 8'h48, 4'b1111);
    step();
    drive(1, 32'h88, 8'h48, 4'b1111);
    step();
    drive(0, 0, 0, 0);
    #2 rst_n = 0;
    #1;
    check("areset_valid", o_valid, 0);
    check("areset_ctrl", o_ctrl, 0);
    check("areset_result", o_result, 0);
    #3 rst_n = 1;
    step();
    check("areset_after_valid", o_valid, 0);
    check("areset_after_ready", o_ready, 1);
    i_ready = 1;
    step();
    check("areset_no_reappear", o_valid, 0);

    // back-to-back throughput
    for (int i = 0; i < 8; i++) begin
      drive(1, 32'h100 + i, 8'h40, 4'b1111);
      #1;
      check($sformatf("b2b_ready_%0d", i), o_ready, 1);
      step();
      check($sformatf("b2b_valid_%0d", i), o_valid, 1);
      check($sformatf("b2b_result_%0d", i), o_result, 32'h100 + i);
    end
    drive(0, 0, 0, 0);
    step();
    check("b2b_end", o_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
